float_accum_16bit: RTL and testbench
====================================

FLOAT_ACCUM_16BIT -- requirements
Module: float_accum_16bit

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the term counter.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port nRST, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port clear, input, 1 bit: synchronous abort that zeroes the accumulator.
REQ-005 The block SHALL have port in_valid, input, 1 bit: a product is presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a product this cycle.
REQ-007 The block SHALL have port product, input, HALF_FLOAT_W (16) bits: an IEEE half-precision term from float_mult_16bit.
REQ-008 The block SHALL have port in_last, input, 1 bit: the accepted term is the final term of the dot product.
REQ-009 The block SHALL have port out_valid, output, 1 bit: sum is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes sum.
REQ-011 The block SHALL have port sum, output, 16 bits: the accumulated half-precision result.
REQ-012 The block SHALL have port term_cnt, output, CNT_W bits: the number of terms accepted since the last clear or handoff.

Function
REQ-013 The block SHALL implement the FSM states IDLE, ALIGN, ADD, NORM, ROUND and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE with clear=0.
REQ-015 A handshake (in_valid&in_ready) SHALL latch product and in_last and move the FSM to ALIGN.
REQ-016 The FSM SHALL then advance ALIGN->ADD->NORM->ROUND, one cycle each, and write acc at the end of ROUND.
REQ-017 After ROUND the FSM SHALL return to IDLE, or go to DONE if the latched in_last=1; throughput is therefore one term per 5 cycles.
REQ-018 ALIGN SHALL unpack both operands, with subnormals using exponent 1 and no hidden bit, and right-shift the smaller-magnitude significand by the exponent difference into a 14-bit datapath (11 bits + guard + round + sticky); a shift of 14 or more SHALL leave only the sticky bit.
REQ-019 ADD SHALL add the aligned significands if the signs are equal, otherwise subtract smaller from larger, taking the sign of the larger magnitude.
REQ-020 NORM SHALL shift right 1 on carry-out, or left by the leading-zero count, stopping at exponent 1 to produce a subnormal.
REQ-021 ROUND SHALL increment the mantissa when the guard bit is 1, as float_mult_16bit does.
REQ-022 A mantissa carry in ROUND SHALL increment the exponent.
REQ-023 An exponent of 31 or more SHALL produce ±Inf with the result sign.
REQ-024 An exact-zero result SHALL be +0 (0x0000).
REQ-025 A NaN operand (exp all ones, mant≠0) SHALL give 0xFFFF; Inf + opposite Inf SHALL give 0xFFFF.
REQ-026 Inf + finite SHALL give that Inf; once acc is NaN it SHALL stay NaN until clear or handoff.
REQ-027 In DONE, out_valid SHALL be 1 and sum SHALL equal acc; both SHALL be held stable until out_ready=1.
REQ-028 On out_ready=1 in DONE, the block SHALL set acc to 0, term_cnt to 0 and out_valid to 0, and return to IDLE.
REQ-029 Outside DONE, out_valid SHALL be 0 and sum SHALL be 0.
REQ-030 term_cnt SHALL increment on each handshake and saturate at all ones.
REQ-031 clear=1 in any state SHALL force IDLE, acc=0, term_cnt=0 and out_valid=0 on the next edge, and discard any term in flight.
REQ-032 clear SHALL take priority over a simultaneous in_valid or out_ready.

Reset
REQ-033 nRST=0 SHALL immediately force state to IDLE, acc to 0x0000 and term_cnt to 0, clearing all datapath registers.
REQ-034 During and after reset, in_ready SHALL read 1 only once nRST=1; out_valid=0 and sum=0.
REQ-035 A reset mid-operation SHALL discard the in-flight term with no output.

Structure
REQ-036 HALF_FLOAT_W, HALF_EXPONENT_W, HALF_FRACTION_W, HALF_ZERO, exp_t and mant_t SHALL come from fpu_types_pkg.
REQ-037 The new accum_state_t enum and the HALF_QNAN constant (16'hFFFF) SHALL be added to fpu_types_pkg.
REQ-038 The leading-zero count SHALL be one sub-module, lzc_14bit, a combinational 14-bit input to 4-bit count.
REQ-039 Everything else SHALL be one always_ff for the state/registers plus one always_comb for next-state/datapath.

Verification
REQ-040 Scenario: 0x3C00 then 0x3C00 with in_last, out_ready=1 -> sum=0x4000 with out_valid 5 cycles after the second handshake; term_cnt=2 while valid.
REQ-041 Scenario: 0x3C00 then 0xBC00 (last) -> sum=0x0000.
REQ-042 Scenario: 0x7BFF then 0x7BFF (last) -> sum=0x7C00; then 0x7C00 then 0xFC00 -> sum=0xFFFF.
REQ-043 Scenario: 0x0001 then 0x0001 (last) -> sum=0x0002; 0x0400 then 0x8001 -> sum=0x03FF.
REQ-044 Scenario: out_ready held 0 for 10 cycles in DONE -> sum/out_valid stable and in_ready=0; out_ready=1 -> IDLE next cycle with acc=0.
REQ-045 Scenario: clear pulsed in ADD, and nRST pulsed in NORM -> no out_valid, and the next single-term run 0x4200 (last) gives sum=0x4200.

Source files
------------

// File: rtl/fpu_types_pkg.sv
// fpu_types_pkg: shared half-precision widths, types, constants and classifiers
package fpu_types_pkg;
  localparam int HALF_FLOAT_W = 16;
  localparam int HALF_EXPONENT_W = 5;
  localparam int HALF_FRACTION_W = 10;
  localparam logic [HALF_FLOAT_W-1:0] HALF_ZERO = 16'h0000;
  localparam logic [HALF_FLOAT_W-1:0] HALF_QNAN = 16'hFFFF;
  typedef logic [HALF_EXPONENT_W-1:0] exp_t;
  typedef logic [HALF_FRACTION_W-1:0] mant_t;
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} accum_state_t;
  function automatic logic is_nan(input exp_t e, input mant_t m);
    return &e && |m;
  endfunction
  function automatic logic is_inf(input exp_t e, input mant_t m);
    return &e && !(|m);
  endfunction
endpackage

// File: rtl/lzc_14bit.sv
// lzc_14bit: leading-zero count of a 14-bit word (14 when the word is zero)
//   din : word to scan, MSB first
//   cnt : number of zeros above the highest set bit
module lzc_14bit (
  input  logic [13:0] din,
  output logic [3:0]  cnt
);
  always_comb begin
    cnt = 4'd14;
    for (int i = 0; i < 14; i++) if (din[i]) cnt = 4'(13 - i);
  end
endmodule

// File: rtl/float_accum_16bit.sv
// float_accum_16bit: multi-cycle half-precision accumulator for dot-product terms
//   CLK/nRST            : clock, asynchronous active-low reset
//   clear               : synchronous abort, zeroes accumulator and count
//   in_valid/in_ready   : term handshake, product + in_last latched on accept
//   out_valid/out_ready : result handshake, sum held until taken
//   term_cnt            : saturating count of terms accepted since clear/handoff
module float_accum_16bit
  import fpu_types_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [HALF_FLOAT_W-1:0] product,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [HALF_FLOAT_W-1:0] sum,
  output logic [CNT_W-1:0]        term_cnt
);
  accum_state_t state, state_n;
  logic [HALF_FLOAT_W-1:0] acc, opnd, spec_val, hi, res;
  logic last_q, spec, sgn, sub;
  logic [5:0] ex, e_hi, e_lo, d, lim, norm_ex, re;
  logic [13:0] big, sml, hi_al, lo_ext, lo_sh, lo_al;
  logic [14:0] mag, lo, add_s, norm_mag;
  logic [3:0] lz, shl;
  logic [11:0] m12;
  logic [10:0] rm;
  logic a_big, lo_stk, nan, any_inf;
  exp_t hi_exp, lo_exp;
  mant_t hi_man, lo_man;
  lzc_14bit u_lzc (.din(mag[13:0]), .cnt(lz));
  assign in_ready = nRST && state == IDLE && !clear;
  assign out_valid = state == DONE;
  assign sum = state == DONE ? acc : HALF_ZERO;
  always_comb begin
    a_big = acc[14:0] >= opnd[14:0];
    hi = a_big ? acc : opnd;
    lo = a_big ? opnd[14:0] : acc[14:0];
    {hi_exp, hi_man} = hi[14:0];
    {lo_exp, lo_man} = lo;
    // subnormals behave as exponent 1 without the hidden bit
    e_hi = {1'b0, hi_exp == 5'd0 ? 5'd1 : hi_exp};
    e_lo = {1'b0, lo_exp == 5'd0 ? 5'd1 : lo_exp};
    d = e_hi - e_lo;
    hi_al = {|hi_exp, hi_man, 3'b000};
    lo_ext = {|lo_exp, lo_man, 3'b000};
    lo_sh = lo_ext >> d;
    lo_stk = |(lo_ext & ~(14'h3FFF << d));
    lo_al = d >= 6'd14 ? {13'd0, |lo_ext} : {lo_sh[13:1], lo_sh[0] | lo_stk};
    nan = is_nan(acc[14:10], acc[9:0]) || is_nan(opnd[14:10], opnd[9:0]) ||
          (is_inf(acc[14:10], acc[9:0]) && is_inf(opnd[14:10], opnd[9:0]) && (acc[15] ^ opnd[15]));
    any_inf = is_inf(acc[14:10], acc[9:0]) || is_inf(opnd[14:10], opnd[9:0]);
    add_s = sub ? {1'b0, big} - {1'b0, sml} : {1'b0, big} + {1'b0, sml};
    // left normalisation never takes the exponent below 1
    lim = ex - 6'd1;
    shl = {2'b00, lz} > lim ? lim[3:0] : lz;
    norm_mag = mag[14] ? {1'b0, mag[14:2], mag[1] | mag[0]} : {1'b0, mag[13:0] << shl};
    norm_ex = mag[14] ? ex + 6'd1 : ex - {2'b00, shl};
    m12 = {1'b0, mag[13:3]} + {11'd0, mag[2]};
    rm = m12[11] ? m12[11:1] : m12[10:0];
    re = ex + {5'd0, m12[11]};
    res = spec ? spec_val :
          re >= 6'd31 ? {sgn, 15'h7C00} :
          rm == 11'd0 ? HALF_ZERO :
          {sgn, rm[10] ? re[4:0] : 5'd0, rm[9:0]};
    case (state)
      IDLE:    state_n = in_valid ? ALIGN : IDLE;
      ALIGN:   state_n = ADD;
      ADD:     state_n = NORM;
      NORM:    state_n = ROUND;
      ROUND:   state_n = last_q ? DONE : IDLE;
      DONE:    state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
    if (clear) state_n = IDLE;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      acc <= HALF_ZERO;
      term_cnt <= '0;
      opnd <= HALF_ZERO;
      last_q <= 1'b0;
      spec <= 1'b0;
      spec_val <= HALF_ZERO;
      sgn <= 1'b0;
      sub <= 1'b0;
      ex <= '0;
      big <= '0;
      sml <= '0;
      mag <= '0;
    end else begin
      state <= state_n;
      if (clear) begin
        acc <= HALF_ZERO;
        term_cnt <= '0;
      end else begin
        case (state)
          IDLE: if (in_valid) begin
            opnd <= product;
            last_q <= in_last;
            term_cnt <= &term_cnt ? term_cnt : term_cnt + 1'b1;
          end
          ALIGN: begin
            big <= hi_al;
            sml <= lo_al;
            sgn <= hi[15];
            sub <= acc[15] ^ opnd[15];
            ex <= e_hi;
            spec <= nan || any_inf;
            spec_val <= nan ? HALF_QNAN : is_inf(acc[14:10], acc[9:0]) ? acc : opnd;
          end
          ADD: mag <= add_s;
          NORM: begin
            mag <= norm_mag;
            ex <= norm_ex;
          end
          ROUND: acc <= res;
          DONE: if (out_ready) begin
            acc <= HALF_ZERO;
            term_cnt <= '0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_float_accum_16bit.sv
// tb_float_accum_16bit: directed and randomized checks against an exact-arithmetic model
module tb_float_accum_16bit;
  localparam int CW = 4;
  logic CLK = 1'b0, nRST = 1'b0, clear = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic out_ready = 1'b0, or_val = 1'b1, rnd_or = 1'b0;
  logic [15:0] product = 16'h0000;
  logic in_ready, out_valid;
  logic [15:0] sum;
  logic [CW-1:0] term_cnt;
  int errs = 0, checks = 0, cyc = 0;
  int m_cnt = 0, m_free = 0;
  logic m_last = 1'b0;
  logic [15:0] m_acc = 16'h0000;
  float_accum_16bit #(.CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .product(product), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .term_cnt(term_cnt)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) begin
    #2;
    out_ready = rnd_or ? 1'($urandom) : or_val;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask
  function automatic longint to_int(input logic [15:0] h);
    int e = h[14:10] == 5'd0 ? 1 : int'(h[14:10]);
    longint m = longint'({h[14:10] != 5'd0, h[9:0]}) << (e - 1);
    return h[15] ? -m : m;
  endfunction
  function automatic logic [15:0] from_int(input longint s);
    longint m = s < 0 ? -s : s;
    logic sg = s < 0;
    longint q;
    int p = 0, sh, ex;
    if (m == 0) return 16'h0000;
    while ((m >> (p + 1)) != 0) p++;
    if (p <= 10) return {sg, 15'(m)};
    sh = p - 10;
    q = (m >> sh) + ((m >> (sh - 1)) & 1);
    if (q == 2048) begin
      q = 1024;
      sh++;
    end
    ex = sh + 1;
    if (ex >= 31) return {sg, 15'h7C00};
    return {sg, 5'(ex), 10'(q - 1024)};
  endfunction
  function automatic logic [15:0] h_add(input logic [15:0] a, input logic [15:0] b);
    logic na = &a[14:10] && |a[9:0], nb = &b[14:10] && |b[9:0];
    logic ia = &a[14:10] && !(|a[9:0]), ib = &b[14:10] && !(|b[9:0]);
    if (na || nb) return 16'hFFFF;
    if (ia && ib) return a[15] != b[15] ? 16'hFFFF : a;
    if (ia) return a;
    if (ib) return b;
    return from_int(to_int(a) + to_int(b));
  endfunction
  always @(negedge CLK) begin
    logic e_done, e_rdy;
    cyc++;
    if (!nRST) begin
      m_acc = 16'h0000;
      m_cnt = 0;
      m_last = 1'b0;
      m_free = cyc;
    end
    e_done = nRST && cyc >= m_free && m_last;
    e_rdy = nRST && cyc >= m_free && !m_last && !clear;
    chk("in_ready", 32'(in_ready), 32'(e_rdy));
    chk("out_valid", 32'(out_valid), 32'(e_done));
    chk("sum", 32'(sum), 32'(e_done ? m_acc : 16'h0000));
    chk("term_cnt", 32'(term_cnt), 32'(m_cnt));
    if (nRST) begin
      if (clear) begin
        m_acc = 16'h0000;
        m_cnt = 0;
        m_last = 1'b0;
        m_free = cyc + 1;
      end else if (e_rdy && in_valid) begin
        m_acc = h_add(m_acc, product);
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        m_last = in_last;
        m_free = cyc + 5;
      end else if (e_done && out_ready) begin
        m_acc = 16'h0000;
        m_cnt = 0;
        m_last = 1'b0;
        m_free = cyc + 1;
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic send(input logic [15:0] p, input logic l);
    int n = 0;
    in_valid = 1'b1;
    product = p;
    in_last = l;
    @(negedge CLK);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge CLK);
    end
    if (n >= 100) chk("send_timeout", 32'(in_ready), 32'd1);
    tick(1);
    in_valid = 1'b0;
  endtask
  task automatic wait_done(input logic [15:0] exp, input int cnt, input string nm, output int lat);
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!out_valid && lat < 100);
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk(nm, 32'(sum), 32'(exp));
    chk({nm, "_cnt"}, 32'(term_cnt), 32'(cnt));
    tick(1);
  endtask
  task automatic run2(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp, input string nm);
    int lat;
    send(a, 1'b0);
    send(b, 1'b1);
    wait_done(exp, 2, nm, lat);
  endtask
  task automatic quiet(input int n);
    repeat (n) begin
      @(negedge CLK);
      chk("no_output", 32'(out_valid), 32'd0);
    end
    tick(1);
  endtask
  function automatic logic [15:0] rand_half();
    int r = $urandom_range(0, 9);
    if (r == 0) return 16'($urandom);
    if (r == 1) begin
      case ($urandom_range(0, 4))
        0: return 16'h7C00;
        1: return 16'hFC00;
        2: return 16'h7E00;
        3: return 16'h8000;
        default: return 16'h7BFF;
      endcase
    end
    if (r <= 3) return {1'($urandom), 5'($urandom_range(0, 2)), 10'($urandom)};
    return {1'($urandom), 5'($urandom_range(12, 18)), 10'($urandom)};
  endfunction
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat;
    tick(3);
    nRST = 1'b1;
    @(negedge CLK);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_sum", 32'(sum), 32'd0);
    tick(1);
    send(16'h3C00, 1'b0);
    send(16'h3C00, 1'b1);
    wait_done(16'h4000, 2, "one_plus_one", lat);
    chk("latency", 32'(lat), 32'd5);
    run2(16'h3C00, 16'hBC00, 16'h0000, "cancel");
    run2(16'h7BFF, 16'h7BFF, 16'h7C00, "overflow");
    run2(16'h7C00, 16'hFC00, 16'hFFFF, "inf_minus_inf");
    run2(16'h0001, 16'h0001, 16'h0002, "subnormal_add");
    run2(16'h0400, 16'h8001, 16'h03FF, "to_subnormal");
    run2(16'h7E00, 16'h3C00, 16'hFFFF, "nan_sticky");
    run2(16'h7C00, 16'h3C00, 16'h7C00, "inf_plus_finite");
    or_val = 1'b0;
    run2(16'h3C00, 16'h4000, 16'h4200, "hold_value");
    repeat (10) begin
      @(negedge CLK);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_sum", 32'(sum), 32'h4200);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    tick(1);
    or_val = 1'b1;
    tick(1);
    @(negedge CLK);
    chk("handoff_idle", 32'(in_ready), 32'd1);
    chk("handoff_cnt", 32'(term_cnt), 32'd0);
    tick(1);
    send(16'h4200, 1'b1);
    wait_done(16'h4200, 1, "after_handoff", lat);
    send(16'h3C00, 1'b1);
    tick(1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    quiet(8);
    send(16'h3C00, 1'b1);
    tick(2);
    nRST = 1'b0;
    tick(1);
    nRST = 1'b1;
    quiet(8);
    send(16'h4200, 1'b1);
    wait_done(16'h4200, 1, "after_abort", lat);
    in_valid = 1'b1;
    product = 16'h3C00;
    in_last = 1'b1;
    clear = 1'b1;
    tick(1);
    in_valid = 1'b0;
    clear = 1'b0;
    @(negedge CLK);
    chk("clear_priority_cnt", 32'(term_cnt), 32'd0);
    tick(1);
    or_val = 1'b0;
    send(16'h3C00, 1'b1);
    wait_done(16'h3C00, 1, "clear_in_done", lat);
    clear = 1'b1;
    or_val = 1'b1;
    tick(1);
    clear = 1'b0;
    @(negedge CLK);
    chk("clear_in_done_valid", 32'(out_valid), 32'd0);
    tick(1);
    for (int i = 0; i < 17; i++) send(16'h3C00, 1'b0);
    send(16'h3C00, 1'b1);
    wait_done(16'h4C80, 15, "saturate", lat);
    rnd_or = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int len = $urandom_range(1, 5);
      for (int j = 0; j < len; j++) begin
        send(rand_half(), j == len - 1);
        tick($urandom_range(0, 2));
        if ($urandom_range(0, 24) == 0) begin
          clear = 1'b1;
          tick(1);
          clear = 1'b0;
        end
      end
    end
    tick(20);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
